endian_swap_stream: RTL and testbench
=====================================

# endian_swap_stream

Streaming, parametrised successor to the fixed 32-bit little-to-big-endian converter. Accepts beats on a valid/ready input, applies a per-beat byte-order transform (pass, full byte reverse, or halfword-internal swap) to data and byte-keep, and presents the result on a registered valid/ready output with a one-entry skid buffer for full throughput. Sits between bus-side ingress logic and any consumer needing network/big-endian order. Also keeps a transfer counter and a sticky illegal-mode flag.

## Interface
- DATA_W, 32, data width in bits; multiple of 16, minimum 16
- CNT_W, 16, width of the beat counter
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  block can accept a beat
- in_data_i  in  DATA_W  input data, byte k = bits [8k+7:8k]
- in_keep_i  in  DATA_W/8  per-byte valid mask, bit k qualifies byte k
- in_mode_i  in  2  transform for this beat, sampled with the beat
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  consumer accepts beat
- out_data_o  out  DATA_W  transformed data
- out_keep_o  out  DATA_W/8  transformed keep mask
- beat_cnt_o  out  CNT_W  count of completed output transfers
- mode_err_o  out  1  sticky, set by an accepted beat with mode 2'b11

## Operation
- N = DATA_W/8 bytes. Input transfer: in_valid_i & in_ready_o. Output transfer: out_valid_o & out_ready_i.
- Modes (index k = source byte, result byte index shown):
  - 2'b00 pass: out byte k = in byte k.
  - 2'b01 full reverse: out byte k = in byte N-1-k (DATA_W=32: 0xAABBCCDD -> 0xDDCCBBAA).
  - 2'b10 halfword swap: within each 16-bit lane, bytes 2j and 2j+1 exchanged (0xAABBCCDD -> 0xBBAADDCC).
  - 2'b11 reserved: data/keep pass unchanged; beat still forwarded; mode_err_o set.
- Keep bits undergo exactly the same permutation as their bytes. Bytes with keep=0 are forwarded as received (no zeroing).
- Storage: output register (out_*) plus one skid register. Transform applied before storage; skid holds already-transformed beat.
- Accept with output register empty, or with output being consumed this cycle: beat goes to output register.
- Accept while output holds an unconsumed beat: beat goes to skid.
- On output transfer with skid full: skid moves to output register, skid empties.
- in_ready_o = skid empty (registered state, no combinational path from out_ready_i).
- beat_cnt_o increments by 1 on each output transfer; saturates at 2^CNT_W-1 (no wrap).
- mode_err_o set on the cycle after an input transfer with in_mode_i=2'b11; cleared only by reset.
- Ordering strictly preserved; no beat dropped or duplicated under any valid/ready pattern.

## Timing
- Reset (synchronous, dominates all other events in the same cycle): out_valid_o=0, out_data_o=0, out_keep_o=0, skid empty, in_ready_o=1 from the first cycle after reset is sampled, beat_cnt_o=0, mode_err_o=0. Beats in flight at reset are discarded.
- Latency: input transfer at edge t -> out_valid_o high after edge t (visible cycle t+1).
- Throughput: one beat/cycle sustained while out_ready_i=1.
- out_valid_o, out_data_o, out_keep_o held stable while out_valid_o=1 and out_ready_i=0.
- Back-pressure: with out_ready_i=0, at most two beats absorbed (output + skid); in_ready_o drops the cycle after the second accept.
- Simultaneous input transfer and output transfer with skid full: cannot occur (in_ready_o=0). With skid empty: new beat lands in output register, skid stays empty.
- beat_cnt_o and mode_err_o are registered; they update one cycle after the triggering transfer.

## Test plan
- Reset then single beat: data 0x11223344, keep 4'b0111, mode 01, out_ready_i=1 -> next cycle out_data_o 0x44332211, out_keep_o 4'b1110, beat_cnt_o=1 one cycle later.
- Mode sweep DATA_W=32 on 0xAABBCCDD: mode 00 -> 0xAABBCCDD; 10 -> 0xBBAADDCC; 11 -> 0xAABBCCDD with mode_err_o=1 thereafter until reset.
- Back-pressure: out_ready_i=0, present beats A,B,C back-to-back -> A in output, B in skid, in_ready_o=0 while C waits; release out_ready_i -> A,B,C emitted in order, no loss.
- Random valid/ready (10k beats, random modes, DATA_W=64) vs scoreboard -> exact data/keep/order match, beat_cnt_o=10000.
- Counter saturation with CNT_W=4: 20 transfers -> beat_cnt_o stops at 15.
- Reset mid-stream with skid full -> next cycle out_valid_o=0, in_ready_o=1, counters zero, stalled beats never appear.

Source files
------------

// File: rtl/endian_swap_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | endian_swap_stream                                                         |
// | Valid/ready byte-order transformer (pass / reverse / halfword swap) with a |
// | registered output, one-entry skid buffer, beat counter, illegal-mode flag. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module endian_swap_stream #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_W-1:0]   in_data_i,
  input  logic [DATA_W/8-1:0] in_keep_i,
  input  logic [1:0]          in_mode_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   out_data_o,
  output logic [DATA_W/8-1:0] out_keep_o,
  output logic [CNT_W-1:0]    beat_cnt_o,
  output logic                mode_err_o
);

  localparam int N = DATA_W / 8;
  localparam logic [1:0] MODE_REV  = 2'b01;
  localparam logic [1:0] MODE_HSWP = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  logic [DATA_W-1:0] xf_data;
  logic [N-1:0]      xf_keep;

  // Byte k of the result selects its source byte; keep follows the same mapping.
  generate
    for (genvar k = 0; k < N; k++) begin : g_byte
      assign xf_data[8*k +: 8] =
          (in_mode_i == MODE_REV)  ? in_data_i[8*(N-1-k) +: 8] :
          (in_mode_i == MODE_HSWP) ? in_data_i[8*(k^1) +: 8]   :
                                     in_data_i[8*k +: 8];
      assign xf_keep[k] =
          (in_mode_i == MODE_REV)  ? in_keep_i[N-1-k] :
          (in_mode_i == MODE_HSWP) ? in_keep_i[k^1]   :
                                     in_keep_i[k];
    end
  endgenerate

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [N-1:0]      out_keep_q,  out_keep_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [N-1:0]      skid_keep_q,  skid_keep_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid_i & ~skid_valid_q;
  assign out_fire = out_valid_q & out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_keep_d  = skid_keep_q;
    cnt_d        = cnt_q;
    err_d        = err_q;

    if (out_fire) begin
      // A full skid blocks input, so refill from skid never competes with a new beat.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_keep_d   = skid_keep_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_data_d = xf_data;
        out_keep_d = xf_keep;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = xf_data;
        out_keep_d  = xf_keep;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = xf_data;
        skid_keep_d  = xf_keep;
      end
    end

    if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (in_fire && (in_mode_i == MODE_RSVD)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_keep_q  <= skid_keep_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_keep_o  = out_keep_q;
  assign beat_cnt_o  = cnt_q;
  assign mode_err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_endian_swap_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_endian_swap_stream                                                      |
// | Directed vectors, back-pressure, saturation, random stream, mid reset.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_endian_swap_stream;

  localparam int DATA_W = 32;
  localparam int N      = DATA_W / 8;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [N-1:0]      in_keep;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [N-1:0]      out_keep;
  logic [CNT_W-1:0]  beat_cnt;
  logic              mode_err;

  always #5 clk = ~clk;

  endian_swap_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_keep_i  (in_keep),
    .in_mode_i  (in_mode),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_keep_o (out_keep),
    .beat_cnt_o (beat_cnt),
    .mode_err_o (mode_err)
  );

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [N-1:0]      k;
    logic [1:0]        m;
    logic [DATA_W-1:0] ed;
    logic [N-1:0]      ek;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [N-1:0]      k;
  } beat_t;

  int total = 0;
  int bad   = 0;
  beat_t exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic exp_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t model(input logic [DATA_W-1:0] d, input logic [N-1:0] k,
                                  input logic [1:0] m);
    beat_t r;
    int src;
    for (int i = 0; i < N; i++) begin
      case (m)
        2'b01:   src = N - 1 - i;
        2'b10:   src = (i % 2 == 0) ? i + 1 : i - 1;
        default: src = i;
      endcase
      r.d[8*i +: 8] = d[8*src +: 8];
      r.k[i]        = k[src];
    end
    return r;
  endfunction

  // Scoreboard: transfers are judged at negedge, where inputs are stable.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      exp_q.delete();
      exp_cnt = '0;
      exp_err = 1'b0;
    end else begin
      check("beat_cnt_track", {60'd0, beat_cnt}, {60'd0, exp_cnt});
      check("mode_err_track", {63'd0, mode_err}, {63'd0, exp_err});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", {32'd0, out_data}, {32'd0, e.d});
          check("sb_keep", {60'd0, out_keep}, {60'd0, e.k});
        end
        if (exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, in_keep, in_mode));
        if (in_mode == 2'b11) exp_err = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DATA_W-1:0] d, input logic [N-1:0] k, input logic [1:0] m);
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_mode  = m;
  endtask

  vec_t vecs[6];
  beat_t a_exp;
  logic acc;
  int w, sent, cyc;

  initial begin
    vecs[0] = '{d: 32'h11223344, k: 4'b0111, m: 2'b01, ed: 32'h44332211, ek: 4'b1110};
    vecs[1] = '{d: 32'hAABBCCDD, k: 4'b1111, m: 2'b00, ed: 32'hAABBCCDD, ek: 4'b1111};
    vecs[2] = '{d: 32'hAABBCCDD, k: 4'b0001, m: 2'b10, ed: 32'hBBAADDCC, ek: 4'b0010};
    vecs[3] = '{d: 32'hAABBCCDD, k: 4'b0011, m: 2'b01, ed: 32'hDDCCBBAA, ek: 4'b1100};
    vecs[4] = '{d: 32'h12345678, k: 4'b0100, m: 2'b10, ed: 32'h34127856, ek: 4'b1000};
    vecs[5] = '{d: 32'hAABBCCDD, k: 4'b0101, m: 2'b11, ed: 32'hAABBCCDD, ek: 4'b0101};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_mode = '0; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_data",  {32'd0, out_data},  64'd0);
    check("rst_out_keep",  {60'd0, out_keep},  64'd0);
    check("rst_cnt",       {60'd0, beat_cnt},  64'd0);
    check("rst_err",       {63'd0, mode_err},  64'd0);

    // Single-beat vectors, one-cycle latency each
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].d, vecs[i].k, vecs[i].m);
      tick();
      in_valid = 1'b0;
      check("vec_valid", {63'd0, out_valid}, 64'd1);
      check("vec_data",  {32'd0, out_data},  {32'd0, vecs[i].ed});
      check("vec_keep",  {60'd0, out_keep},  {60'd0, vecs[i].ek});
      tick();
      check("vec_cnt",   {60'd0, beat_cnt},  64'(i + 1));
      check("vec_drain", {63'd0, out_valid}, 64'd0);
    end
    check("err_after_rsvd", {63'd0, mode_err}, 64'd1);

    // Back-pressure: A to output, B to skid, C waits
    out_ready = 1'b0;
    drive(32'hA0A1A2A3, 4'b1111, 2'b01);
    a_exp = model(32'hA0A1A2A3, 4'b1111, 2'b01);
    tick();
    check("bp_ready_after_A", {63'd0, in_ready}, 64'd1);
    drive(32'hB0B1B2B3, 4'b0011, 2'b10);
    tick();
    drive(32'hC0C1C2C3, 4'b1001, 2'b00);
    check("bp_ready_low", {63'd0, in_ready}, 64'd0);
    check("bp_hold_A",    {32'd0, out_data}, {32'd0, a_exp.d});
    tick();
    check("bp_still_low", {63'd0, in_ready}, 64'd0);
    check("bp_stable_A",  {32'd0, out_data}, {32'd0, a_exp.d});
    check("bp_valid",     {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    w = 0;
    acc = 1'b0;
    while (!acc && w < 10) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      w++;
    end
    in_valid = 1'b0;
    if (!acc) begin total++; bad++; $display("FAIL bp_accept_C: got timeout expected accept"); end
    repeat (4) tick();
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("bp_cnt",         {60'd0, beat_cnt}, 64'd9);

    // Saturation: 11 more back-to-back beats take 9 -> 20 transfers
    for (int i = 0; i < 11; i++) begin
      drive(32'(i * 32'h01010101), 4'b1111, 2'(i % 3));
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("sat_cnt", {60'd0, beat_cnt}, 64'd15);

    // Random valid/ready stream with scoreboard
    sent = 0;
    cyc  = 0;
    while (sent < 400 && cyc < 5000) begin
      if (!in_valid && $urandom_range(0, 3) != 0)
        drive($urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        in_valid = 1'b0;
        sent++;
      end
    end
    in_valid = 1'b0;
    if (sent < 400) begin total++; bad++; $display("FAIL rand_budget: got %0d expected 400", sent); end
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin tick(); w++; end
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    check("rand_cnt_sat",     {60'd0, beat_cnt}, 64'd15);

    // Reset with output and skid full; stalled beats must vanish
    out_ready = 1'b0;
    drive(32'hDEAD0001, 4'b1111, 2'b00);
    tick();
    drive(32'hDEAD0002, 4'b1111, 2'b00);
    tick();
    drive(32'hDEAD0003, 4'b1111, 2'b00);
    tick();
    check("mr_skid_full", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("mr_out_valid", {63'd0, out_valid}, 64'd0);
    check("mr_in_ready",  {63'd0, in_ready},  64'd1);
    check("mr_cnt",       {60'd0, beat_cnt},  64'd0);
    check("mr_err",       {63'd0, mode_err},  64'd0);
    check("mr_data",      {32'd0, out_data},  64'd0);
    out_ready = 1'b1;
    repeat (5) tick();
    check("mr_no_ghost", {63'd0, out_valid}, 64'd0);
    drive(32'h01020304, 4'b1000, 2'b10);
    tick();
    in_valid = 1'b0;
    check("mr_post_data", {32'd0, out_data}, 64'h02010403);
    check("mr_post_keep", {60'd0, out_keep}, 64'h4);
    tick();
    check("mr_post_cnt",  {60'd0, beat_cnt}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
